line_mem_adapter: RTL
=====================

# line_mem_adapter

Converts whole-cache-line transactions from the L1 cache controller into sequences of single-word transfers on the main-memory bus, and back. On a fill it reads `WORDS_PER_LINE` consecutive words and returns one assembled line. On a writeback it captures a line and writes it to memory word by word. It sits between the cache datapath/controller and the word-wide memory port of the multicycle OTTER.

## Interface
Parameters:
- `WORD_W`, 32: memory word width in bits.
- `WORDS_PER_LINE`, 8: words per cache line; must be a power of two, ≥2.
- `ADDR_W`, 32: byte-address width.
- Derived: `LINE_W = WORD_W*WORDS_PER_LINE`; `OFF_W = log2(WORDS_PER_LINE*WORD_W/8)`.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `line_read_req`  in  1  request a line fill, sampled only in IDLE.
- `line_write_req`  in  1  request a line writeback, sampled only in IDLE.
- `line_addr`  in  ADDR_W  line byte address; low OFF_W bits are ignored and treated as zero.
- `line_wdata`  in  LINE_W  writeback line; word i is bits [i*WORD_W +: WORD_W].
- `line_rdata`  out  LINE_W  assembled fill line, same word ordering.
- `line_resp`  out  1  one-cycle completion pulse.
- `line_err`  out  1  one-cycle abort pulse, coincident with `line_resp`.
- `busy`  out  1  high whenever the state is not IDLE.
- `mem_addr`  out  ADDR_W  word byte address.
- `mem_rden`  out  1  word read request.
- `mem_wren`  out  1  word write request.
- `mem_wdata`  out  WORD_W  write data.
- `mem_rdata`  in  WORD_W  read data, valid when `mem_ack` is high.
- `mem_ack`  in  1  completes the current word transfer.

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE**
  - `line_write_req` high: latch the aligned base address and `line_wdata`, clear word counter `cnt`, go to WRITE.
  - Else `line_read_req` high: latch the base address, clear `cnt`, go to READ.
  - Both high: write wins and the read is dropped. The controller must re-issue the read.
- **READ**
  - `mem_rden`=1, `mem_addr = base + cnt*(WORD_W/8)`.
  - On a cycle with `mem_ack`: store `mem_rdata` into word `cnt` of the line buffer and increment `cnt`.
  - When `cnt` is `WORDS_PER_LINE-1` at the ack, go to DONE.
- **WRITE**: same sequencing with `mem_wren`=1 and `mem_wdata` = captured word `cnt`.
- **DONE**: `line_resp`=1 for exactly one cycle, then IDLE.
- Requests while `busy` are ignored.
- `line_rdata` holds the last completed fill until the next fill completes. Partial fills never alter it: assemble into a shadow buffer and copy in DONE.
- `mem_addr`, `mem_wdata` and the request strobe are stable from assertion until `mem_ack`.
- `mem_rden` and `mem_wren` are never high together.
- Address arithmetic is modulo 2^ADDR_W. The offset never carries out of the line because the base is aligned.

## Timing
- Reset (`rst_n` low, asynchronous): state IDLE, `cnt`=0, all outputs 0 including `line_rdata`, `mem_addr`, `mem_wdata`.
- Reset asserted mid-transfer aborts immediately. No `line_resp` is generated.
- Request sampled at edge E. The memory strobe is high in the cycle after E.
- Words transfer back-to-back: one word per cycle while `mem_ack` is held high, with no idle gap between words.
- With `mem_ack` tied high:
  - Strobe is high for exactly `WORDS_PER_LINE` cycles.
  - `line_resp` is high in cycle E+`WORDS_PER_LINE`+1.
  - `busy` rises after E and falls after the `line_resp` cycle.
- The memory may stall by holding `mem_ack` low for any number of cycles (subject to Configuration).
- `mem_rdata` is sampled only on ack cycles.

## Configuration
- `LINE_MEM_ADAPTER_TIMEOUT_EN` defined:
  - An 8-bit stall counter clears on each ack and on entry to READ/WRITE.
  - If it reaches 255 with no `mem_ack`, go to DONE and pulse `line_resp` and `line_err` together.
  - A fill aborted this way leaves `line_rdata` unchanged.
- Not defined: no stall counter, the adapter waits indefinitely, and `line_err` is tied 0.

## Test plan
- Fill, `mem_ack` always 1, `line_addr`=0x1000_0014:
  - `mem_addr` steps 0x1000_0000..0x1000_001C on consecutive cycles.
  - Memory returns word i = 0xA000_0000+i.
  - `line_rdata` word i matches; `line_resp` 9 cycles after the request edge.
- Writeback of `line_wdata` words 0xB0..0xB7 with `mem_ack` toggling 1,0,1,0: each word is held until its ack, 8 writes in order, single `line_resp`, no `mem_rden` activity.
- Both requests in the same cycle: a writeback runs, no read occurs. A `line_read_req` pulsed while `busy` is ignored.
- Reset asserted during word 3 of a fill:
  - All outputs go 0 immediately.
  - The prior `line_rdata` is cleared and no `line_resp` is generated.
  - A new fill after reset works.
- With `LINE_MEM_ADAPTER_TIMEOUT_EN` defined, ack withheld from word 2:
  - `line_resp` and `line_err` pulse together after 255 stall cycles.
  - `line_rdata` is unchanged and state returns to IDLE.
- Without the macro, the same stimulus leaves `busy` high indefinitely and `line_err` never rises.

Source files
------------

// File: rtl/line_mem_adapter.sv
// ---------------------------------------------------------------------------
// line_mem_adapter
//
// Bridges whole-cache-line transactions from the L1 cache controller onto a
// word-wide main-memory bus. A fill reads WORDS_PER_LINE consecutive words and
// returns one assembled line; a writeback captures a line and writes it to
// memory one word at a time.
//
// Optional feature:
//   LINE_MEM_ADAPTER_TIMEOUT_EN - when defined, a transfer that sees no
//   mem_ack for 255 consecutive stall cycles is aborted and completes with
//   line_resp and line_err pulsed together. When undefined the adapter waits
//   indefinitely and line_err is tied low.
//
// Ports:
//   clk            - sole clock, rising edge
//   rst_n          - asynchronous active-low reset
//   line_read_req  - line fill request (sampled only while idle)
//   line_write_req - line writeback request (sampled only while idle, wins
//                    over a simultaneous read request)
//   line_addr      - line byte address, low OFF_W bits ignored
//   line_wdata     - writeback line, word i at [i*WORD_W +: WORD_W]
//   line_rdata     - last completed fill line, same word ordering
//   line_resp      - one-cycle completion pulse
//   line_err       - one-cycle abort pulse, coincident with line_resp
//   busy           - high while a transaction is in progress
//   mem_addr       - word byte address presented to memory
//   mem_rden       - word read strobe
//   mem_wren       - word write strobe
//   mem_wdata      - word write data
//   mem_rdata      - word read data, valid with mem_ack
//   mem_ack        - completes the current word transfer
// ---------------------------------------------------------------------------
module line_mem_adapter #(
    parameter  int WORD_W         = 32,
    parameter  int WORDS_PER_LINE = 8,
    parameter  int ADDR_W         = 32,
    localparam int LINE_W         = WORD_W * WORDS_PER_LINE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_read_req,
    input  logic              line_write_req,
    input  logic [ADDR_W-1:0] line_addr,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_resp,
    output logic              line_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int BYTE_SH = $clog2(WORD_W / 8);
    localparam int OFF_W   = $clog2(WORDS_PER_LINE * WORD_W / 8);
    localparam int CNT_W   = $clog2(WORDS_PER_LINE);

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] base;
    logic [LINE_W-1:0] wbuf;
    logic [LINE_W-1:0] shadow;
    logic [LINE_W-1:0] shadow_merged;
    logic [ADDR_W-1:0] cur_addr;
    logic [WORD_W-1:0] wbuf_word;
    logic              last_word;
    logic              stall_expire;

    assign cur_addr  = base + (ADDR_W'(cnt) << BYTE_SH);
    assign wbuf_word = wbuf[int'(cnt) * WORD_W +: WORD_W];
    assign last_word = (cnt == LAST_CNT);

    // Shadow buffer with the word currently on mem_rdata slotted in.
    always_comb begin
        shadow_merged = shadow;
        shadow_merged[int'(cnt) * WORD_W +: WORD_W] = mem_rdata;
    end

`ifdef LINE_MEM_ADAPTER_TIMEOUT_EN
    logic [7:0] stall_cnt;
    logic       err_q;

    // The counter would reach 255 on this edge: this is the 255th stall cycle.
    assign stall_expire = !mem_ack && (stall_cnt == 8'd254);
    assign line_err     = (state == S_DONE) && err_q;
`else
    assign stall_expire = 1'b0;
    assign line_err     = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and bus outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        busy      = (state != S_IDLE);
        line_resp = 1'b0;
        mem_rden  = 1'b0;
        mem_wren  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_IDLE: begin
                if (line_write_req) begin
                    state_n = S_WRITE;
                end else if (line_read_req) begin
                    state_n = S_READ;
                end
            end
            S_READ: begin
                mem_rden = 1'b1;
                mem_addr = cur_addr;
                if ((mem_ack && last_word) || stall_expire) begin
                    state_n = S_DONE;
                end
            end
            S_WRITE: begin
                mem_wren  = 1'b1;
                mem_addr  = cur_addr;
                mem_wdata = wbuf_word;
                if ((mem_ack && last_word) || stall_expire) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                line_resp = 1'b1;
                state_n   = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: base address, word counter, line buffers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            base       <= '0;
            wbuf       <= '0;
            shadow     <= '0;
            line_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (line_write_req) begin
                        base <= line_addr & ~OFF_MASK;
                        wbuf <= line_wdata;
                        cnt  <= '0;
                    end else if (line_read_req) begin
                        base <= line_addr & ~OFF_MASK;
                        cnt  <= '0;
                    end
                end
                S_READ: begin
                    if (mem_ack) begin
                        shadow <= shadow_merged;
                        cnt    <= cnt + CNT_W'(1);
                        // Publish the completed line on the final ack so it
                        // is already valid during the line_resp cycle; an
                        // aborted fill never reaches this and leaves
                        // line_rdata untouched.
                        if (last_word) begin
                            line_rdata <= shadow_merged;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LINE_MEM_ADAPTER_TIMEOUT_EN
    // -----------------------------------------------------------------------
    // Stall watchdog
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (line_write_req || line_read_req) begin
                        stall_cnt <= '0;
                        err_q     <= 1'b0;
                    end
                end
                S_READ, S_WRITE: begin
                    if (mem_ack) begin
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + 8'd1;
                        if (stall_expire) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
`endif

endmodule
